ahbwaitram: RTL

AHB-Lite subordinate RAM with a configurable number of wait states, used as the uncore RAM in simulation and FPGA builds to stress the bus interface and LSU/IFU bus FSMs. It sits directly downstream of the AHB interconnect/decoder and is selected over the `P.UNCORE_RAM_BASE`..`+P.UNCORE_RAM_RANGE` window. All sizing comes from the shared `cvw_t` configuration:

- `P.AHBW` sets the data width.
- `P.PA_BITS` sets the address width.
- `P.RAM_LATENCY` sets the wait states.
- `P.BURST_EN` enables burst acceleration.

---
 rtl/ahbwaitram.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ahbwaitram.sv
// ahbwaitram: AHB-Lite subordinate RAM with a configurable number of wait
// states, used as the uncore RAM to stress manager-side bus FSMs.
//
// Optional feature macro: AHBWAITRAM_RANGECHK_EN
//   defined   - addresses beyond DEPTH words inside the uncore RAM window
//               get the two-cycle ERROR response (no write, HRDATA unchanged)
//   undefined - the word index wraps modulo DEPTH, HRESP is tied to 0
//
// Parameters:
//   P      configuration record (AHBW, PA_BITS, RAM_LATENCY, BURST_EN,
//          UNCORE_RAM_BASE, UNCORE_RAM_RANGE)
//   DEPTH  number of AHBW-wide words (power of two)
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HREADY         address phase from the decoder / bus
//   HWDATA, HWSTRB         write data and byte enables (data phase)
//   HRDATA, HREADYOUT,
//   HRESP                  read data, ready and response back to the bus
//
// States:
//   S_IDLE | no transfer in flight, ready
//   S_WAIT | wait states counting down, not ready
//   S_DATA | final data-phase cycle, ready, write commits at its end
//   S_ERR1 | first error cycle, not ready, HRESP=1
//   S_ERR2 | second error cycle, ready, HRESP=1

package ahbwaitram_cfg_pkg;
  typedef struct packed {
    int unsigned AHBW;
    int unsigned PA_BITS;
    int unsigned RAM_LATENCY;
    logic        BURST_EN;
    logic [63:0] UNCORE_RAM_BASE;
    logic [63:0] UNCORE_RAM_RANGE;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{
    AHBW:             32,
    PA_BITS:          32,
    RAM_LATENCY:      2,
    BURST_EN:         1'b1,
    UNCORE_RAM_BASE:  64'h0000_0000_8000_0000,
    UNCORE_RAM_RANGE: 64'h0000_0000_0FFF_FFFF
  };
endpackage

module ahbwaitram
  import ahbwaitram_cfg_pkg::*;
#(
  parameter cvw_t P     = CVW_DEFAULT,
  parameter int   DEPTH = 4096
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic [P.PA_BITS-1:0]   HADDR,
  input  logic [P.AHBW-1:0]      HWDATA,
  input  logic [P.AHBW/8-1:0]    HWSTRB,
  input  logic                   HWRITE,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [P.AHBW-1:0]      HRDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP
);

  localparam int unsigned AHBW    = P.AHBW;
  localparam int unsigned PA_BITS = P.PA_BITS;
  localparam int          BYTES   = AHBW / 8;
  localparam int          IDX_LO  = $clog2(BYTES);
  localparam int          IDX_W   = $clog2(DEPTH);
  localparam int          CW      = (P.RAM_LATENCY == 0) ? 1 : $clog2(P.RAM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_CNT = CW'(P.RAM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt, acc_idx, rd_idx;
  logic               wr_q, wr_nxt;
  logic [AHBW-1:0]    hrdata_q, rd_word, rd_fwd;
  logic               load_rd, accept, seq_fast, addr_err, commit;
  logic               unused_haddr;

  logic [AHBW-1:0]    mem [DEPTH];

  assign acc_idx   = HADDR[IDX_LO +: IDX_W];
  assign HREADYOUT = (state != S_WAIT) && (state != S_ERR1);
  // Only a ready data phase can overlap a new address phase.
  assign accept    = HSEL & HTRANS[1] & HREADY & HREADYOUT;
  assign seq_fast  = P.BURST_EN & HTRANS[0];
  assign commit    = (state == S_DATA) & wr_q;
  assign HRDATA    = hrdata_q;

  // Low byte-lane bits and out-of-window bits never select a word.
  assign unused_haddr = ^HADDR;

`ifdef AHBWAITRAM_RANGECHK_EN
  localparam logic [PA_BITS-1:0] WIN_MASK = PA_BITS'(P.UNCORE_RAM_RANGE);
  localparam logic [PA_BITS-1:0] RAM_MASK = PA_BITS'(DEPTH * BYTES - 1);

  // Any offset bit inside the window but above the RAM itself is out of range.
  assign addr_err = |(HADDR & WIN_MASK & ~RAM_MASK);
  assign HRESP    = (state == S_ERR1) || (state == S_ERR2);
`else
  assign addr_err = 1'b0;
  assign HRESP    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    wr_nxt    = wr_q;
    load_rd   = 1'b0;
    rd_idx    = idx_q;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept) begin
          idx_nxt = acc_idx;
          wr_nxt  = HWRITE;
          if (addr_err) begin
            state_nxt = S_ERR1;
          end else if (seq_fast || (P.RAM_LATENCY == 0)) begin
            state_nxt = S_DATA;
            load_rd   = ~HWRITE;
            rd_idx    = acc_idx;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = LAT_CNT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = S_DATA;
          load_rd   = ~wr_q;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A zero-wait read pipelined behind a write to the same word must see the
  // bytes being committed on this very edge.
  always_comb begin
    rd_word = mem[rd_idx];
    rd_fwd  = rd_word;
    for (int b = 0; b < BYTES; b++) begin
      if (commit && (idx_q == rd_idx) && HWSTRB[b]) begin
        rd_fwd[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx_q <= idx_nxt;
      wr_q  <= wr_nxt;
      if (load_rd) begin
        hrdata_q <= rd_fwd;
      end
    end
  end

  // Contents survive reset; a reset forces S_IDLE so a pending write is lost.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (HWSTRB[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule
